// File: rtl/wb_port_scheduler_if.sv
// Bundles the write-back, LLU, register-file and hazard-probe signals of the
// write-port scheduler. The slave modport is the scheduler's view; the master
// modport is the view of the surrounding pipeline.
interface wb_port_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  // write-back stage request
  logic              pipe_we;
  logic [5:0]        pipe_addr;
  logic [DATA_W-1:0] pipe_data;
  // long-latency unit result handshake
  logic              llu_valid;
  logic              llu_ready;
  logic [5:0]        llu_addr;
  logic [DATA_W-1:0] llu_data;
  // register-file write port
  logic              rf_we;
  logic [5:0]        rf_addr;
  logic [DATA_W-1:0] rf_data;
  // pipeline control and hazard probe
  logic              stall_req;
  logic [5:0]        chk_addr;
  logic              chk_hit;
  logic [CW-1:0]     q_count;

  modport slave (
    input  pipe_we, pipe_addr, pipe_data,
    input  llu_valid, llu_addr, llu_data,
    output llu_ready,
    output rf_we, rf_addr, rf_data,
    output stall_req,
    input  chk_addr,
    output chk_hit, q_count
  );

  modport master (
    output pipe_we, pipe_addr, pipe_data,
    output llu_valid, llu_addr, llu_data,
    input  llu_ready,
    input  rf_we, rf_addr, rf_data,
    input  stall_req,
    output chk_addr,
    input  chk_hit, q_count
  );
endinterface

// File: rtl/wb_port_scheduler.sv
// Purpose: arbitrates the single register-file write port between write-back (priority) and a queued LLU.
// Latency: selected write appears on rf_* one edge later; an LLU result needs at least two edges.
// Backpressure: llu_ready drops when the queue is full; stall_req holds the pipe when full or starved.
//
// Ports: clk/reset (async, active-high) plain; everything else through bus (slave modport):
//   pipe_* write-back request, llu_* LLU result handshake, rf_* registered write port,
//   stall_req pipeline hold, chk_addr/chk_hit hazard probe, q_count queue occupancy.
module wb_port_scheduler #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  wb_port_scheduler_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  // queue storage; payload is not reset, validity lives in r_vld
  logic [5:0]        r_q_addr [DEPTH];
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [DEPTH-1:0]  r_kill;
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic [SW-1:0]     r_starve;
  logic              r_rf_we;
  logic [5:0]        r_rf_addr;
  logic [DATA_W-1:0] r_rf_data;

  logic w_full;
  logic w_empty;
  logic w_stall;
  logic w_llu_ready;
  logic w_wb_acc;
  logic w_deq;
  logic w_push;
  logic w_head_kill;
  logic w_chk_hit;

  assign w_full  = (r_count == FULL);
  assign w_empty = (r_count == '0);

  // Both handshake outputs come from registered state only; reset forces them low.
  assign w_stall     = !reset && (w_full || (r_starve == SLIM));
  assign w_llu_ready = !reset && !w_full;

  // A stalled stage re-presents its write later, so pipe_we is ignored while stalling.
  assign w_wb_acc = !w_stall && bus.pipe_we && (bus.pipe_addr != 6'd0);
  assign w_deq    = !w_empty && (w_stall || !w_wb_acc);

  // Writes to r0 are handshaken but never queued.
  assign w_push      = bus.llu_valid && w_llu_ready && (bus.llu_addr != 6'd0);
  assign w_head_kill = r_kill[r_head];

  always_comb begin
    w_chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && !r_kill[i] && (r_q_addr[i] == bus.chk_addr))
        w_chk_hit = 1'b1;
    end
    if (bus.chk_addr == 6'd0 || reset)
      w_chk_hit = 1'b0;
  end

  // payload write at the tail
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_tail] <= bus.llu_addr;
      r_q_data[r_tail] <= bus.llu_data;
    end
  end

  // Per-entry valid/kill. The tail slot is never valid when a push happens, so a
  // same-cycle write-back cannot kill the entry being enqueued (it is younger).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld  <= '0;
      r_kill <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (r_tail == PW'(i))) begin
          r_vld[i]  <= 1'b1;
          r_kill[i] <= 1'b0;
        end else if (w_deq && (r_head == PW'(i))) begin
          r_vld[i]  <= 1'b0;
          r_kill[i] <= 1'b0;
        end else if (w_wb_acc && r_vld[i] && (r_q_addr[i] == bus.pipe_addr)) begin
          r_kill[i] <= 1'b1;
        end
      end
    end
  end

  // pointers, occupancy and starvation counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_deq)  r_head <= r_head + PW'(1);
      case ({w_push, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_deq || w_empty)
        r_starve <= '0;
      else if (w_wb_acc && (r_starve != SLIM))
        r_starve <= r_starve + SW'(1);
    end
  end

  // registered write port; a killed head frees its slot but writes nothing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rf_we   <= 1'b0;
      r_rf_addr <= '0;
      r_rf_data <= '0;
    end else begin
      r_rf_we <= w_wb_acc || (w_deq && !w_head_kill);
      if (w_wb_acc) begin
        r_rf_addr <= bus.pipe_addr;
        r_rf_data <= bus.pipe_data;
      end else if (w_deq && !w_head_kill) begin
        r_rf_addr <= r_q_addr[r_head];
        r_rf_data <= r_q_data[r_head];
      end
    end
  end

  assign bus.llu_ready = w_llu_ready;
  assign bus.stall_req = w_stall;
  assign bus.rf_we     = r_rf_we;
  assign bus.rf_addr   = r_rf_addr;
  assign bus.rf_data   = r_rf_data;
  assign bus.chk_hit   = w_chk_hit;
  assign bus.q_count   = reset ? '0 : r_count;
endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed bench for wb_port_scheduler: write-back only, idle drain, full queue,
// starvation, WAW kill and asynchronous reset mid-operation.
module tb_wb_port_scheduler;
  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  wb_port_scheduler_if #(.DATA_W(32), .DEPTH(4)) bus ();

  wb_port_scheduler #(.DATA_W(32), .DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus.pipe_we = 1'b0; bus.pipe_addr = '0; bus.pipe_data = '0;
    bus.llu_valid = 1'b0; bus.llu_addr = '0; bus.llu_data = '0;
    bus.chk_addr = '0;

    // ---- reset state
    #3;
    chk("rst_rf_we",     bus.rf_we, 0);
    chk("rst_rf_addr",   bus.rf_addr, 0);
    chk("rst_rf_data",   bus.rf_data, 0);
    chk("rst_llu_ready", bus.llu_ready, 0);
    chk("rst_stall",     bus.stall_req, 0);
    chk("rst_q_count",   bus.q_count, 0);
    chk("rst_chk_hit",   bus.chk_hit, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rel_llu_ready", bus.llu_ready, 1);

    // ---- write-back only
    bus.pipe_we = 1'b1; bus.pipe_addr = 6'd5; bus.pipe_data = 32'hA5;
    tick();
    chk("wb_rf_we",   bus.rf_we, 1);
    chk("wb_rf_addr", bus.rf_addr, 5);
    chk("wb_rf_data", bus.rf_data, 32'hA5);
    bus.pipe_addr = 6'd0; bus.pipe_data = 32'hFF;
    tick();
    chk("wb_r0_rf_we", bus.rf_we, 0);
    bus.pipe_we = 1'b0;

    // ---- LLU result to r0 is handshaken but dropped
    bus.llu_valid = 1'b1; bus.llu_addr = 6'd0; bus.llu_data = 32'hDEAD;
    #1;
    chk("r0_llu_ready", bus.llu_ready, 1);
    tick();
    chk("r0_q_count", bus.q_count, 0);
    chk("r0_rf_we",   bus.rf_we, 0);

    // ---- LLU idle drain
    bus.llu_addr = 6'd9; bus.llu_data = 32'h1234; bus.chk_addr = 6'd9;
    tick();
    bus.llu_valid = 1'b0;
    #1;
    chk("drain_q1",      bus.q_count, 1);
    chk("drain_chk_hit", bus.chk_hit, 1);
    chk("drain_e1_we",   bus.rf_we, 0);
    tick();
    chk("drain_rf_we",   bus.rf_we, 1);
    chk("drain_rf_addr", bus.rf_addr, 9);
    chk("drain_rf_data", bus.rf_data, 32'h1234);
    chk("drain_q0",      bus.q_count, 0);
    chk("drain_chk_clr", bus.chk_hit, 0);

    // ---- full queue with write-back every cycle
    for (int i = 0; i < 4; i++) begin
      bus.pipe_we = 1'b1; bus.pipe_addr = 6'd20; bus.pipe_data = 32'h2000 + i;
      bus.llu_valid = 1'b1; bus.llu_addr = 6'(10 + i); bus.llu_data = 32'h100 + i;
      tick();
      chk("full_q_count", bus.q_count, i + 1);
      chk("full_wb_addr", bus.rf_addr, 20);
    end
    bus.llu_valid = 1'b0;
    #1;
    chk("full_llu_ready", bus.llu_ready, 0);
    chk("full_stall",     bus.stall_req, 1);
    bus.pipe_addr = 6'd21; bus.pipe_data = 32'h777;
    tick();
    chk("full_deq_we",    bus.rf_we, 1);
    chk("full_deq_addr",  bus.rf_addr, 10);
    chk("full_deq_data",  bus.rf_data, 32'h100);
    chk("full_q3",        bus.q_count, 3);
    chk("full_unstall",   bus.stall_req, 0);
    chk("full_ready_up",  bus.llu_ready, 1);
    tick();
    chk("full_wb2_addr",  bus.rf_addr, 21);
    chk("full_wb2_data",  bus.rf_data, 32'h777);
    bus.pipe_we = 1'b0;
    for (int j = 1; j < 4; j++) begin
      tick();
      chk("full_drain_addr", bus.rf_addr, 10 + j);
      chk("full_drain_data", bus.rf_data, 32'h100 + j);
    end
    chk("full_drain_q0", bus.q_count, 0);

    // ---- starvation: one queued entry, write-back every cycle
    bus.pipe_we = 1'b1; bus.pipe_addr = 6'd22; bus.pipe_data = 32'h2222;
    bus.llu_valid = 1'b1; bus.llu_addr = 6'd30; bus.llu_data = 32'h3030;
    tick();
    bus.llu_valid = 1'b0;
    chk("starve_q1", bus.q_count, 1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("starve_stall", bus.stall_req, (k == 8) ? 1 : 0);
    end
    chk("starve_wb_addr", bus.rf_addr, 22);
    tick();
    chk("starve_deq_addr", bus.rf_addr, 30);
    chk("starve_deq_data", bus.rf_data, 32'h3030);
    chk("starve_q0",       bus.q_count, 0);
    chk("starve_clear",    bus.stall_req, 0);
    tick();
    chk("starve_wb_again", bus.rf_addr, 22);
    bus.pipe_we = 1'b0;
    tick();
    chk("starve_idle_we", bus.rf_we, 0);

    // ---- WAW kill
    bus.pipe_we = 1'b1; bus.pipe_addr = 6'd23; bus.pipe_data = 32'h23;
    bus.llu_valid = 1'b1; bus.llu_addr = 6'd7; bus.llu_data = 32'h77;
    bus.chk_addr = 6'd7;
    tick();
    chk("waw_q1",     bus.q_count, 1);
    chk("waw_hit_q",  bus.chk_hit, 1);
    bus.llu_valid = 1'b0; bus.pipe_addr = 6'd7; bus.pipe_data = 32'hBEEF;
    tick();
    chk("waw_wb_addr", bus.rf_addr, 7);
    chk("waw_wb_data", bus.rf_data, 32'hBEEF);
    chk("waw_killed",  bus.chk_hit, 0);
    chk("waw_q_kept",  bus.q_count, 1);
    bus.pipe_data = 32'hBEF2;
    bus.llu_valid = 1'b1; bus.llu_addr = 6'd7; bus.llu_data = 32'h701;
    tick();
    chk("waw_young_q2",  bus.q_count, 2);
    chk("waw_young_hit", bus.chk_hit, 1);
    chk("waw_wb2_data",  bus.rf_data, 32'hBEF2);
    bus.chk_addr = 6'd0;
    #1;
    chk("waw_chk_r0", bus.chk_hit, 0);
    bus.chk_addr = 6'd7;
    bus.pipe_we = 1'b0; bus.llu_valid = 1'b0;
    tick();
    chk("waw_kill_no_we", bus.rf_we, 0);
    chk("waw_kill_q1",    bus.q_count, 1);
    tick();
    chk("waw_young_we",   bus.rf_we, 1);
    chk("waw_young_addr", bus.rf_addr, 7);
    chk("waw_young_data", bus.rf_data, 32'h701);
    chk("waw_q0",         bus.q_count, 0);

    // ---- asynchronous reset mid-operation
    bus.pipe_we = 1'b1; bus.pipe_addr = 6'd24; bus.pipe_data = 32'h24;
    for (int i = 0; i < 3; i++) begin
      bus.llu_valid = 1'b1; bus.llu_addr = 6'(40 + i); bus.llu_data = 32'h400 + i;
      tick();
    end
    bus.llu_valid = 1'b0; bus.pipe_we = 1'b0; bus.chk_addr = 6'd40;
    #1;
    chk("mid_q3",      bus.q_count, 3);
    chk("mid_we_live", bus.rf_we, 1);
    chk("mid_hit",     bus.chk_hit, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_we",    bus.rf_we, 0);
    chk("mid_rst_q",     bus.q_count, 0);
    chk("mid_rst_ready", bus.llu_ready, 0);
    chk("mid_rst_stall", bus.stall_req, 0);
    chk("mid_rst_hit",   bus.chk_hit, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rel_ready", bus.llu_ready, 1);
    chk("mid_rel_q",     bus.q_count, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_write", bus.rf_we, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
